// File: rtl/crack_sched.sv
`default_nettype none
// ============================================================================
//  Module      : crack_sched
//  Description : Key-search scheduler for two cracking cores. It launches
//                both cores on disjoint halves of the 24-bit key space,
//                collects the first found key (or both "exhausted" flags),
//                aborts the cores, and arbitrates their shared ciphertext
//                memory port round-robin while the search runs.
//                Optional watchdog: define CRACK_TIMEOUT_EN to bound the
//                RUN phase to TIMEOUT_CYCLES clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module crack_sched #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic        timeout,
    output logic [7:0]  ct_addr,
    input  logic [7:0]  ct_rddata,
    output logic [1:0]  c_en,
    input  logic [1:0]  c_rdy,
    output logic [47:0] c_start_key,
    input  logic [47:0] c_key,
    input  logic [1:0]  c_key_valid,
    input  logic [1:0]  c_done,
    output logic [1:0]  c_abort,
    input  logic [1:0]  c_ct_req,
    input  logic [15:0] c_ct_addr,
    output logic [1:0]  c_ct_gnt,
    output logic [1:0]  c_ct_rvalid,
    output logic [7:0]  c_ct_rddata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    // Core 1 searches the upper half of the key space, core 0 the lower half.
    localparam logic [47:0] C_LAUNCH_KEYS = {24'h800000, 24'h000000};

    state_t      state_q, state_d;
    logic [23:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic [1:0]  abort_q, abort_d;
    logic [1:0]  done_q, done_d;
    logic        last_q;
    logic [1:0]  rvalid_q;
    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_accept;
    logic        w_key_hit;
    logic        w_to_hit;

    assign w_accept  = (state_q == S_IDLE) && en;
    assign w_key_hit = (state_q == S_RUN) && (|c_key_valid);

`ifdef CRACK_TIMEOUT_EN
    logic [31:0] run_cnt_q;
    logic        timeout_q;

    // Watchdog fires in the RUN cycle that completes TIMEOUT_CYCLES RUN cycles.
    assign w_to_hit = (state_q == S_RUN) && ((run_cnt_q + 32'd1) == TIMEOUT_CYCLES);
    assign timeout  = timeout_q;

    // RUN-cycle counter (cleared while launching) and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt_q <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == S_LAUNCH) begin
                run_cnt_q <= 32'd0;
            end else if (state_q == S_RUN) begin
                run_cnt_q <= run_cnt_q + 32'd1;
            end
            if (w_accept) begin
                timeout_q <= 1'b0;
            end else if (w_to_hit && !w_key_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_to_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Scheduler next-state: launch, collect result or exhaustion, drain cores.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        abort_d     = 2'b00;
        done_d      = done_q;
        c_en        = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d     = S_LAUNCH;
                    key_d       = 24'h000000;
                    key_valid_d = 1'b0;
                end
            end
            S_LAUNCH: begin
                done_d = 2'b00;
                if (c_rdy == 2'b11) begin
                    c_en    = 2'b11;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                done_d = done_q | c_done;
                // A found key outranks both the watchdog and exhaustion;
                // core 0 wins a same-cycle tie.
                if (c_key_valid[0]) begin
                    key_d       = c_key[23:0];
                    key_valid_d = 1'b1;
                    abort_d     = 2'b11;
                    state_d     = S_DRAIN;
                end else if (c_key_valid[1]) begin
                    key_d       = c_key[47:24];
                    key_valid_d = 1'b1;
                    abort_d     = 2'b11;
                    state_d     = S_DRAIN;
                end else if (w_to_hit) begin
                    key_valid_d = 1'b0;
                    abort_d     = 2'b11;
                    state_d     = S_DRAIN;
                end else if ((done_q | c_done) == 2'b11) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (c_rdy == 2'b11) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scheduler state and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            key_q       <= 24'h000000;
            key_valid_q <= 1'b0;
            abort_q     <= 2'b00;
            done_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            abort_q     <= abort_d;
            done_q      <= done_d;
        end
    end

    // Memory arbiter: same-cycle grant, round-robin on contention, RUN only.
    always_comb begin
        w_req = (state_q == S_RUN) ? c_ct_req : 2'b00;
        w_gnt = 2'b00;
        case (w_req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = last_q ? 2'b01 : 2'b10;
            default: w_gnt = 2'b00;
        endcase
    end

    // Last-granted pointer and one-cycle-delayed read-return strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= 1'b1;
            rvalid_q <= 2'b00;
        end else begin
            if (|w_gnt) begin
                last_q <= w_gnt[1];
            end
            rvalid_q <= w_gnt;
        end
    end

    assign ct_addr     = w_gnt[1] ? c_ct_addr[15:8] :
                         (w_gnt[0] ? c_ct_addr[7:0] : 8'h00);
    assign rdy         = (state_q == S_IDLE);
    assign key         = key_q;
    assign key_valid   = key_valid_q;
    assign c_start_key = C_LAUNCH_KEYS;
    assign c_abort     = abort_q;
    assign c_ct_gnt    = w_gnt;
    assign c_ct_rvalid = rvalid_q;
    assign c_ct_rddata = ct_rddata;

endmodule
`default_nettype wire

// File: tb/tb_crack_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crack_sched
//  Description : Self-checking bench for crack_sched; the bench plays both
//                cores and the ciphertext memory. Expected keys and grants
//                are queued when stimulus is driven and popped on output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crack_sched;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic        key_valid;
    logic        timeout;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_rddata;
    logic [1:0]  c_en;
    logic [1:0]  c_rdy;
    logic [47:0] c_start_key;
    logic [47:0] c_key;
    logic [1:0]  c_key_valid;
    logic [1:0]  c_done;
    logic [1:0]  c_abort;
    logic [1:0]  c_ct_req;
    logic [15:0] c_ct_addr;
    logic [1:0]  c_ct_gnt;
    logic [1:0]  c_ct_rvalid;
    logic [7:0]  c_ct_rddata;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] exp_keys[$];
    logic [1:0]  exp_rv[$];
    logic        m_last = 1'b1;

    crack_sched #(.TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
        .key_valid(key_valid), .timeout(timeout), .ct_addr(ct_addr),
        .ct_rddata(ct_rddata), .c_en(c_en), .c_rdy(c_rdy),
        .c_start_key(c_start_key), .c_key(c_key), .c_key_valid(c_key_valid),
        .c_done(c_done), .c_abort(c_abort), .c_ct_req(c_ct_req),
        .c_ct_addr(c_ct_addr), .c_ct_gnt(c_ct_gnt), .c_ct_rvalid(c_ct_rvalid),
        .c_ct_rddata(c_ct_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (rdy !== 1'b1 && k < 10) begin
            tick(); #3;
            k++;
        end
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_idle: rdy=%0b want 1", tag, rdy);
        end
    endtask

    // Accept en with both cores idle, leave the DUT in its first RUN cycle.
    task automatic start_search();
        tick(); en = 1'b1; c_rdy = 2'b11;
        tick(); en = 1'b0;
        tick(); c_rdy = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; c_rdy = 2'b11; c_ct_req = 2'b11;
        repeat (3) tick();
        #3;
        n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %0b want 1", rdy); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_key_valid: got %0b want 0", key_valid); end
        n_cmp++; if (key !== 24'h0) begin n_err++; $display("FAIL reset_key: got %h want 000000", key); end
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
        n_cmp++; if (c_en !== 2'b00) begin n_err++; $display("FAIL reset_c_en: got %b want 00", c_en); end
        n_cmp++; if (c_ct_gnt !== 2'b00 || ct_addr !== 8'h00) begin
            n_err++; $display("FAIL reset_arb: gnt=%b addr=%h want 00/00", c_ct_gnt, ct_addr);
        end
        en = 1'b0; c_ct_req = 2'b00; c_rdy = 2'b00;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_launch();
        tick(); en = 1'b1; #3;
        n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL launch_rdy_idle: got %0b want 1", rdy); end
        tick(); en = 1'b0; #3;
        n_cmp++; if (rdy !== 1'b0 || c_en !== 2'b00) begin
            n_err++; $display("FAIL launch_hold: rdy=%0b c_en=%b want 0/00", rdy, c_en);
        end
        tick(); c_rdy = 2'b11; #3;
        n_cmp++; if (c_en !== 2'b11) begin n_err++; $display("FAIL launch_c_en: got %b want 11", c_en); end
        n_cmp++; if (c_start_key !== 48'h800000_000000) begin
            n_err++; $display("FAIL launch_start_key: got %h want 800000000000", c_start_key);
        end
        tick(); c_rdy = 2'b00; #3;
        n_cmp++; if (c_en !== 2'b00 || rdy !== 1'b0) begin
            n_err++; $display("FAIL launch_pulse_end: c_en=%b rdy=%0b want 00/0", c_en, rdy);
        end
    endtask

    task automatic test_key_found();
        tick(); c_key = {24'h800123, 24'h000000}; c_key_valid = 2'b10;
        exp_keys.push_back(24'h800123); #3;
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL found_early: key_valid=%0b want 0", key_valid); end
        tick(); c_key_valid = 2'b00; en = 1'b1; #3;
        n_cmp++; if (key_valid !== 1'b1 || key !== exp_keys[0]) begin
            n_err++; $display("FAIL found_key: key=%h v=%0b want %h/1", key, key_valid, exp_keys[0]);
        end
        n_cmp++; if (c_abort !== 2'b11) begin n_err++; $display("FAIL found_abort: got %b want 11", c_abort); end
        tick(); en = 1'b0; c_rdy = 2'b11; #3;
        n_cmp++; if (c_abort !== 2'b00 || rdy !== 1'b0) begin
            n_err++; $display("FAIL found_abort_end: abort=%b rdy=%0b want 00/0", c_abort, rdy);
        end
        tick(); #3;
        n_cmp++; if (rdy !== 1'b1 || c_en !== 2'b00) begin
            n_err++; $display("FAIL found_idle: rdy=%0b c_en=%b want 1/00", rdy, c_en);
        end
        n_cmp++; if (key_valid !== 1'b1 || key !== exp_keys[0]) begin
            n_err++; $display("FAIL found_hold: key=%h v=%0b want %h/1", key, key_valid, exp_keys[0]);
        end
        void'(exp_keys.pop_front());
    endtask

    task automatic test_tie();
        start_search();
        tick(); c_key = {24'h800777, 24'h000042}; c_key_valid = 2'b11;
        exp_keys.push_back(24'h000042);
        tick(); c_key_valid = 2'b00; #3;
        n_cmp++; if (key !== exp_keys[0] || key_valid !== 1'b1) begin
            n_err++; $display("FAIL tie_key: key=%h v=%0b want %h/1", key, key_valid, exp_keys[0]);
        end
        void'(exp_keys.pop_front());
        c_rdy = 2'b11;
        wait_idle("tie");
    endtask

    task automatic test_arbitration();
        logic [1:0] reqs [8];
        logic [1:0] g;
        logic [1:0] rv;
        logic [7:0] a;
        reqs = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
        start_search();
        for (int i = 0; i < 8; i++) begin
            tick(); c_ct_req = reqs[i]; ct_rddata = 8'h10 + 8'(i); #3;
            if (reqs[i] == 2'b11) g = m_last ? 2'b01 : 2'b10;
            else g = reqs[i];
            if (g != 2'b00) m_last = g[1];
            a = g[1] ? 8'hB1 : (g[0] ? 8'hA0 : 8'h00);
            rv = (exp_rv.size() > 0) ? exp_rv.pop_front() : 2'b00;
            exp_rv.push_back(g);
            n_cmp++; if (c_ct_gnt !== g || ct_addr !== a) begin
                n_err++; $display("FAIL arb_gnt[%0d]: gnt=%b addr=%h want %b/%h", i, c_ct_gnt, ct_addr, g, a);
            end
            n_cmp++; if (c_ct_rvalid !== rv || c_ct_rddata !== 8'h10 + 8'(i)) begin
                n_err++; $display("FAIL arb_rvalid[%0d]: rv=%b data=%h want %b/%h", i, c_ct_rvalid, c_ct_rddata, rv, 8'h10 + 8'(i));
            end
        end
        exp_rv.delete();
        // Grant in the last RUN cycle must still return data.
        tick(); c_ct_req = 2'b01; c_done = 2'b11; #3;
        m_last = 1'b0;
        n_cmp++; if (c_ct_gnt !== 2'b01 || ct_addr !== 8'hA0) begin
            n_err++; $display("FAIL arb_last_gnt: gnt=%b addr=%h want 01/a0", c_ct_gnt, ct_addr);
        end
        tick(); c_done = 2'b00; c_ct_req = 2'b11; ct_rddata = 8'h5A; #3;
        n_cmp++; if (c_ct_gnt !== 2'b00 || c_ct_rvalid !== 2'b01 || c_ct_rddata !== 8'h5A) begin
            n_err++; $display("FAIL arb_exit: gnt=%b rv=%b data=%h want 00/01/5a", c_ct_gnt, c_ct_rvalid, c_ct_rddata);
        end
        c_ct_req = 2'b00; c_rdy = 2'b11;
        wait_idle("arb");
    endtask

    task automatic test_exhausted();
        start_search();
        tick(); c_done = 2'b01; #3;
        n_cmp++; if (rdy !== 1'b0 || c_abort !== 2'b00) begin
            n_err++; $display("FAIL done_partial: rdy=%0b abort=%b want 0/00", rdy, c_abort);
        end
        tick(); c_done = 2'b00;
        repeat (4) tick();
        tick(); c_done = 2'b10;
        tick(); c_done = 2'b00; #3;
        n_cmp++; if (key_valid !== 1'b0 || key !== 24'h0 || c_abort !== 2'b00) begin
            n_err++; $display("FAIL done_result: key=%h v=%0b abort=%b want 000000/0/00", key, key_valid, c_abort);
        end
        c_rdy = 2'b11;
        wait_idle("done");
        // Core results outside RUN are ignored.
        tick(); c_key = {24'h0, 24'h0000AA}; c_key_valid = 2'b01; c_done = 2'b11;
        tick(); c_key_valid = 2'b00; c_done = 2'b00; #3;
        n_cmp++; if (key_valid !== 1'b0 || key !== 24'h0 || rdy !== 1'b1) begin
            n_err++; $display("FAIL idle_ignore: key=%h v=%0b rdy=%0b want 000000/0/1", key, key_valid, rdy);
        end
    endtask

`ifdef CRACK_TIMEOUT_EN
    task automatic test_timeout();
        start_search();
        for (int k = 1; k <= 100; k++) begin
            tick(); #3;
            if (k == 99) begin
                n_cmp++; if (timeout !== 1'b0 || rdy !== 1'b0) begin
                    n_err++; $display("FAIL to_early: timeout=%0b rdy=%0b want 0/0", timeout, rdy);
                end
            end
        end
        n_cmp++; if (timeout !== 1'b1 || c_abort !== 2'b11 || key_valid !== 1'b0) begin
            n_err++; $display("FAIL to_fire: timeout=%0b abort=%b v=%0b want 1/11/0", timeout, c_abort, key_valid);
        end
        tick(); c_rdy = 2'b11; #3;
        n_cmp++; if (c_abort !== 2'b00) begin n_err++; $display("FAIL to_abort_end: got %b want 00", c_abort); end
        wait_idle("to");
        n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_hold: got %0b want 1", timeout); end
    endtask
`else
    task automatic test_timeout();
        start_search();
        repeat (110) tick();
        #3;
        n_cmp++; if (timeout !== 1'b0 || rdy !== 1'b0 || c_abort !== 2'b00) begin
            n_err++; $display("FAIL no_watchdog: timeout=%0b rdy=%0b abort=%b want 0/0/00", timeout, rdy, c_abort);
        end
        tick(); c_done = 2'b11;
        tick(); c_done = 2'b00; c_rdy = 2'b11;
        wait_idle("nowd");
    endtask
`endif

    task automatic test_reset_midsearch();
        start_search();
        tick(); rst = 1'b1; #1;
        n_cmp++; if (rdy !== 1'b1 || c_abort !== 2'b00 || c_en !== 2'b00) begin
            n_err++; $display("FAIL async_reset: rdy=%0b abort=%b c_en=%b want 1/00/00", rdy, c_abort, c_en);
        end
        tick(); #3;
        n_cmp++; if (c_abort !== 2'b00) begin n_err++; $display("FAIL async_reset_abort: got %b want 00", c_abort); end
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; c_rdy = 2'b00; c_key = 48'h0; c_key_valid = 2'b00;
        c_done = 2'b00; c_ct_req = 2'b00; c_ct_addr = {8'hB1, 8'hA0}; ct_rddata = 8'h00;
        test_reset();
        test_launch();
        test_key_found();
        test_tie();
        test_arbitration();
        test_exhausted();
        test_timeout();
        test_reset_midsearch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crack_sched.md
CRACK_SCHED -- requirements
Module: crack_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd50_000_000, the RUN-state cycle limit (used only with CRACK_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-004 SHALL have port en, input, 1 bit, the start request, sampled only while rdy=1.
REQ-005 SHALL have port rdy, output, 1 bit, high when idle and able to accept en.
REQ-006 SHALL have port key, output, 24 bits, the found key.
REQ-007 SHALL have port key_valid, output, 1 bit, high when key holds a found key.
REQ-008 SHALL have port timeout, output, 1 bit, high when the last search was ended by the watchdog.
REQ-009 SHALL have port ct_addr, output, 8 bits, the shared ciphertext memory address.
REQ-010 SHALL have port ct_rddata, input, 8 bits, the memory read data, valid one cycle after ct_addr.
REQ-011 SHALL have ports c_en, output, 2 bits, and c_rdy, input, 2 bits, the per-core start/idle handshake.
REQ-012 SHALL have port c_start_key, output, 48 bits, two 24-bit start keys (core i at bits [24i+23:24i]).
REQ-013 SHALL have ports c_key, input, 48 bits, and c_key_valid, input, 2 bits, the per-core found-key results.
REQ-014 SHALL have ports c_done, input, 2 bits (core exhausted its range, no key), and c_abort, output, 2 bits (stop-search pulse).
REQ-015 SHALL have ports c_ct_req, input, 2 bits; c_ct_addr, input, 16 bits; c_ct_gnt, output, 2 bits; c_ct_rvalid, output, 2 bits; and c_ct_rddata, output, 8 bits, the per-core memory request/grant/return.

Function
REQ-016 SHALL implement FSM IDLE -> LAUNCH -> RUN -> DRAIN -> IDLE.
REQ-017 In IDLE, rdy=1; en=1 at a clock edge SHALL move to LAUNCH, clear key_valid, timeout and key, and drop rdy on the same edge.
REQ-018 In LAUNCH, SHALL hold until c_rdy=2'b11, then pulse c_en=2'b11 for exactly one cycle with c_start_key = {24'h800000, 24'h000000}, and enter RUN.
REQ-019 In RUN, first c_key_valid[i] seen SHALL latch c_key[i] into key, set key_valid next cycle, pulse c_abort=2'b11 for one cycle, and enter DRAIN.
REQ-020 If both c_key_valid bits rise in the same cycle, SHALL take core 0's key.
REQ-021 If both cores have asserted c_done (in any cycles) with no key, SHALL enter DRAIN with key_valid=0 and key=0; no abort is issued.
REQ-022 In DRAIN, SHALL wait for c_rdy=2'b11, then return to IDLE; key, key_valid and timeout hold until the next accepted en.
REQ-023 Memory arbitration SHALL be active only in RUN; elsewhere c_ct_gnt=0.
REQ-024 With one requester, SHALL grant it the same cycle (combinational c_ct_gnt), with ct_addr = that core's c_ct_addr byte.
REQ-025 With both requesting, SHALL grant round-robin against a registered last-granted pointer (reset to core 1, so core 0 wins first).
REQ-026 SHALL grant at most one core per cycle.
REQ-027 SHALL assert c_ct_rvalid[i] exactly one cycle after granting core i; c_ct_rddata = ct_rddata.
REQ-028 A grant issued in the cycle RUN is left SHALL still produce its rvalid.
REQ-029 en while rdy=0 SHALL be ignored.
REQ-030 c_key_valid and c_done outside RUN SHALL be ignored.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE with rdy=1, key=0, key_valid=0, timeout=0, c_en=0, c_abort=0, c_ct_gnt=0, c_ct_rvalid=0, ct_addr=0, and RR pointer=core 1.
REQ-032 Reset mid-search SHALL NOT issue c_abort; cores are reset by their own reset.

Configuration
REQ-033 With CRACK_TIMEOUT_EN defined, SHALL count RUN cycles in a 32-bit counter cleared on RUN entry.
REQ-034 When that counter reaches TIMEOUT_CYCLES, SHALL pulse c_abort=2'b11, set timeout=1 and key_valid=0, and enter DRAIN.
REQ-035 If timeout and a c_key_valid coincide, SHALL treat the key as found.
REQ-036 Without CRACK_TIMEOUT_EN, SHALL contain no counter, and timeout SHALL be constant 0.

Verification
REQ-037 SHALL test reset with en=1 held -> rdy=1, key_valid=0, no c_en pulse.
REQ-038 SHALL test en pulse with both cores idle -> one-cycle c_en=2'b11, c_start_key=48'h800000_000000, rdy=0.
REQ-039 SHALL test core 1 reporting c_key=24'h800123 -> key=24'h800123, key_valid=1 next cycle, one-cycle c_abort=2'b11, rdy=1 after c_rdy=2'b11.
REQ-040 SHALL test both cores requesting memory continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each rvalid lags its grant by exactly 1 cycle.
REQ-041 SHALL test c_done=2'b01 then, 5 cycles later, c_done=2'b10 -> key_valid=0, key=0, return to IDLE.
REQ-042 SHALL test, with CRACK_TIMEOUT_EN and TIMEOUT_CYCLES=100, no result within 100 RUN cycles -> timeout=1, c_abort pulse, key_valid=0.
